// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: default PC geometry, reset/trap vectors and
// the next-PC source encoding used by the PC mux and by debug/trace.
package cpu_pkg;

    localparam int          PC_WIDTH_DEF     = 32;
    localparam int          PC_INC_DEF       = 4;
    localparam int          RAS_DEPTH_DEF    = 4;
    localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC_DEF  = 32'h0000_0100;

    typedef enum logic [2:0] {
        PC_SEQ  = 3'd0,
        PC_BR   = 3'd1,
        PC_JMP  = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4,
        PC_TRAP = 3'd5
    } pc_sel_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty leaves state untouched; both error cases raise a one-cycle flag.
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         push_data_i,
    output logic [WIDTH-1:0]         top_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             full_s;
    logic             empty_s;

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == {CW{1'b0}});

    // Pointer always addresses the next free slot, so the top sits one below it.
    assign top_o       = mem_q[ptr_q - PW'(1)];
    assign count_o     = count_q;
    assign empty_o     = empty_s;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

    // Next pointer/count/flag state; pop takes precedence if both are requested.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (pop_i) begin
            if (empty_s) begin
                unf_d = 1'b1;
            end else begin
                ptr_d   = ptr_q - PW'(1);
                count_d = count_q - CW'(1);
            end
        end else if (push_i) begin
            ptr_d = ptr_q + PW'(1);
            if (full_s) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !pop_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit at the head of fetch: priority next-PC selection
// (trap > ret > call > jmp > branch > sequential), stall hold and a return-address stack.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH_DEF,
    parameter int               INC       = PC_INC_DEF,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC_DEF),
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(PC_TRAP_VEC_DEF),
    parameter int               RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         Stall,
    input  logic                         Trap,
    input  logic                         Ret,
    input  logic                         Call,
    input  logic                         Jmp,
    input  logic [WIDTH-1:0]             Jmp_target,
    input  logic                         Br_taken,
    input  logic [WIDTH-1:0]             Br_target,
    output logic [WIDTH-1:0]             Pc_out,
    output logic [WIDTH-1:0]             Pc_next,
    output logic [$clog2(RAS_DEPTH):0]   Ras_count,
    output logic                         Ras_overflow,
    output logic                         Ras_underflow
);

    localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(INC - 1));

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH-1:0] pc_next_s;
    logic [WIDTH-1:0] ras_top_s;
    pc_sel_t          sel_s;
    logic             hold_s;
    logic             push_s;
    logic             pop_s;
    logic             ras_empty_s;

    assign pc_inc_s = pc_q + INC_W;

    // Priority next-PC mux; evaluated even while stalled so fetch can prefetch.
    always_comb begin
        sel_s     = PC_SEQ;
        pc_next_s = pc_inc_s;
        if (Trap) begin
            sel_s     = PC_TRAP;
            pc_next_s = TRAP_VEC & ALIGN_MASK;
        end else if (Ret) begin
            sel_s = PC_RET;
            if (ras_empty_s) begin
                pc_next_s = pc_inc_s;
            end else begin
                pc_next_s = ras_top_s & ALIGN_MASK;
            end
        end else if (Call) begin
            sel_s     = PC_CALL;
            pc_next_s = Jmp_target & ALIGN_MASK;
        end else if (Jmp) begin
            sel_s     = PC_JMP;
            pc_next_s = Jmp_target & ALIGN_MASK;
        end else if (Br_taken) begin
            sel_s     = PC_BR;
            pc_next_s = Br_target & ALIGN_MASK;
        end else begin
            sel_s     = PC_SEQ;
            pc_next_s = pc_inc_s;
        end
    end

    // Trap breaks through a stall; a trap never selects call/ret, so the RAS stays put.
    assign hold_s = Stall & ~Trap;
    assign push_s = ~hold_s & (sel_s == PC_CALL);
    assign pop_s  = ~hold_s & (sel_s == PC_RET);
    assign pc_d   = hold_s ? pc_q : pc_next_s;

    // Architectural PC register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (Clk),
        .rst_ni      (Rst_n),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .push_data_i (pc_inc_s),
        .top_o       (ras_top_s),
        .count_o     (Ras_count),
        .empty_o     (ras_empty_s),
        .overflow_o  (Ras_overflow),
        .underflow_o (Ras_underflow)
    );

    assign Pc_out  = pc_q;
    assign Pc_next = pc_next_s;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, randomized traffic against a
// queue-based reference model, mid-cycle reset and an 8-bit wrap instance.
module tb_pc_unit;

    localparam logic [5:0] NONE  = 6'b000000;
    localparam logic [5:0] BR    = 6'b000001;
    localparam logic [5:0] JMP   = 6'b000010;
    localparam logic [5:0] CALL  = 6'b000100;
    localparam logic [5:0] RET   = 6'b001000;
    localparam logic [5:0] TRAP  = 6'b010000;
    localparam logic [5:0] STALL = 6'b100000;

    typedef struct {
        logic [5:0]  req;
        logic [31:0] jt;
        logic [31:0] bt;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        ov;
        logic        un;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Stall, Trap, Ret, Call, Jmp, Br_taken;
    logic [31:0] Jmp_target, Br_target;
    logic [31:0] Pc_out, Pc_next;
    logic [2:0]  Ras_count;
    logic        Ras_overflow, Ras_underflow;

    logic        rst8_n;
    logic        zero_b = 1'b0;
    logic [7:0]  zero_w8 = 8'h00;
    logic [7:0]  pc8_out, pc8_next;
    logic [2:0]  cnt8;
    logic        ov8, un8;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ov, m_un;

    vec_t vecs[$];

    pc_unit dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Trap(Trap), .Ret(Ret), .Call(Call),
        .Jmp(Jmp), .Jmp_target(Jmp_target), .Br_taken(Br_taken), .Br_target(Br_target),
        .Pc_out(Pc_out), .Pc_next(Pc_next), .Ras_count(Ras_count),
        .Ras_overflow(Ras_overflow), .Ras_underflow(Ras_underflow)
    );

    pc_unit #(.WIDTH(8), .INC(4), .RESET_VEC(8'h00), .TRAP_VEC(8'h80), .RAS_DEPTH(4)) dut8 (
        .Clk(Clk), .Rst_n(rst8_n), .Stall(zero_b), .Trap(zero_b), .Ret(zero_b), .Call(zero_b),
        .Jmp(zero_b), .Jmp_target(zero_w8), .Br_taken(zero_b), .Br_target(zero_w8),
        .Pc_out(pc8_out), .Pc_next(pc8_next), .Ras_count(cnt8),
        .Ras_overflow(ov8), .Ras_underflow(un8)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model_next(input logic [5:0] r, input logic [31:0] jt,
                                               input logic [31:0] bt);
        if (r[4]) return 32'h0000_0100;
        if (r[3]) return (m_ras.size() == 0) ? m_pc + 32'd4 : (m_ras[$] & ~32'h3);
        if (r[2]) return jt & ~32'h3;
        if (r[1]) return jt & ~32'h3;
        if (r[0]) return bt & ~32'h3;
        return m_pc + 32'd4;
    endfunction

    task automatic model_update(input logic [5:0] r, input logic [31:0] jt, input logic [31:0] bt);
        logic [31:0] nxt;
        logic [31:0] old_pc;
        nxt    = model_next(r, jt, bt);
        old_pc = m_pc;
        m_ov   = 1'b0;
        m_un   = 1'b0;
        if (r[5] && !r[4]) return;
        m_pc = nxt;
        if (r[4]) return;
        if (r[3]) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            else m_un = 1'b1;
        end else if (r[2]) begin
            m_ras.push_back(old_pc + 32'd4);
            if (m_ras.size() > 4) begin
                void'(m_ras.pop_front());
                m_ov = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_ras.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    task automatic apply(input logic [5:0] r, input logic [31:0] jt, input logic [31:0] bt);
        Stall = r[5]; Trap = r[4]; Ret = r[3]; Call = r[2]; Jmp = r[1]; Br_taken = r[0];
        Jmp_target = jt;
        Br_target  = bt;
    endtask

    task automatic run_cycle(input logic [5:0] r, input logic [31:0] jt, input logic [31:0] bt);
        apply(r, jt, bt);
        #1;
        check("pc_next", Pc_next, model_next(r, jt, bt));
        @(posedge Clk);
        #1;
        model_update(r, jt, bt);
        check("pc_out", Pc_out, m_pc);
        check("ras_count", 32'(Ras_count), 32'(m_ras.size()));
        check("ras_overflow", 32'(Ras_overflow), 32'(m_ov));
        check("ras_underflow", 32'(Ras_underflow), 32'(m_un));
    endtask

    task automatic add(input logic [5:0] r, input logic [31:0] jt, input logic [31:0] bt,
                       input logic [31:0] pc, input logic [2:0] cnt, input logic ov, input logic un);
        vecs.push_back(vec_t'{r, jt, bt, pc, cnt, ov, un});
    endtask

    initial begin
        add(NONE,       32'h0,   32'h0,   32'h4,   3'd0, 1'b0, 1'b0);
        add(NONE,       32'h0,   32'h0,   32'h8,   3'd0, 1'b0, 1'b0);
        add(NONE,       32'h0,   32'h0,   32'hC,   3'd0, 1'b0, 1'b0);
        add(JMP,        32'h20,  32'h0,   32'h20,  3'd0, 1'b0, 1'b0);
        add(BR|JMP,     32'h40,  32'h80,  32'h40,  3'd0, 1'b0, 1'b0);
        add(TRAP|RET|JMP, 32'h300, 32'h0, 32'h100, 3'd0, 1'b0, 1'b0);
        add(BR,         32'h0,   32'h83,  32'h80,  3'd0, 1'b0, 1'b0);
        add(JMP,        32'h10,  32'h0,   32'h10,  3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(STALL|JMP, 32'h200, 32'h0, 32'h10, 3'd0, 1'b0, 1'b0);
        add(STALL|TRAP, 32'h0,   32'h0,   32'h100, 3'd0, 1'b0, 1'b0);
        add(JMP,        32'h10,  32'h0,   32'h10,  3'd0, 1'b0, 1'b0);
        add(CALL,       32'h400, 32'h0,   32'h400, 3'd1, 1'b0, 1'b0);
        add(CALL,       32'h800, 32'h0,   32'h800, 3'd2, 1'b0, 1'b0);
        add(RET,        32'h0,   32'h0,   32'h404, 3'd1, 1'b0, 1'b0);
        add(RET,        32'h0,   32'h0,   32'h14,  3'd0, 1'b0, 1'b0);
        add(JMP,        32'h50,  32'h0,   32'h50,  3'd0, 1'b0, 1'b0);
        add(RET,        32'h0,   32'h0,   32'h54,  3'd0, 1'b0, 1'b1);
        add(NONE,       32'h0,   32'h0,   32'h58,  3'd0, 1'b0, 1'b0);
        add(JMP,        32'h0,   32'h0,   32'h0,   3'd0, 1'b0, 1'b0);
        add(CALL,       32'h100, 32'h0,   32'h100, 3'd1, 1'b0, 1'b0);
        add(CALL,       32'h200, 32'h0,   32'h200, 3'd2, 1'b0, 1'b0);
        add(CALL,       32'h300, 32'h0,   32'h300, 3'd3, 1'b0, 1'b0);
        add(CALL,       32'h400, 32'h0,   32'h400, 3'd4, 1'b0, 1'b0);
        add(CALL,       32'h500, 32'h0,   32'h500, 3'd4, 1'b1, 1'b0);
        add(RET,        32'h0,   32'h0,   32'h404, 3'd3, 1'b0, 1'b0);
        add(RET,        32'h0,   32'h0,   32'h304, 3'd2, 1'b0, 1'b0);
        add(RET,        32'h0,   32'h0,   32'h204, 3'd1, 1'b0, 1'b0);
        add(RET,        32'h0,   32'h0,   32'h104, 3'd0, 1'b0, 1'b0);
        add(RET,        32'h0,   32'h0,   32'h108, 3'd0, 1'b0, 1'b1);
        add(JMP,        32'h600, 32'h0,   32'h600, 3'd0, 1'b0, 1'b0);
        add(CALL,       32'h900, 32'h0,   32'h900, 3'd1, 1'b0, 1'b0);
        add(CALL|RET,   32'h700, 32'h0,   32'h604, 3'd0, 1'b0, 1'b0);
        add(STALL|CALL, 32'h40,  32'h0,   32'h604, 3'd0, 1'b0, 1'b0);
        add(STALL|RET,  32'h0,   32'h0,   32'h604, 3'd0, 1'b0, 1'b0);
        add(RET,        32'h0,   32'h0,   32'h608, 3'd0, 1'b0, 1'b1);
        add(CALL,       32'h703, 32'h0,   32'h700, 3'd1, 1'b0, 1'b0);
        add(RET,        32'h0,   32'h0,   32'h60C, 3'd0, 1'b0, 1'b0);

        // Reset held for two edges
        rst8_n = 1'b0;
        Rst_n  = 1'b0;
        apply(NONE, 32'h0, 32'h0);
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("reset_pc", Pc_out, 32'h0);
        check("reset_count", 32'(Ras_count), 32'd0);
        check("reset_ovf", 32'(Ras_overflow), 32'd0);
        check("reset_unf", 32'(Ras_underflow), 32'd0);
        Rst_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            run_cycle(vecs[i].req, vecs[i].jt, vecs[i].bt);
            check($sformatf("tbl%0d_pc", i), Pc_out, vecs[i].pc);
            check($sformatf("tbl%0d_cnt", i), 32'(Ras_count), 32'(vecs[i].cnt));
            check($sformatf("tbl%0d_ovf", i), 32'(Ras_overflow), 32'(vecs[i].ov));
            check($sformatf("tbl%0d_unf", i), 32'(Ras_underflow), 32'(vecs[i].un));
        end

        // Stall with pending jump keeps advertising the jump target
        apply(STALL|JMP, 32'h200, 32'h0);
        #1;
        check("stall_pc_next", Pc_next, 32'h200);
        @(posedge Clk);
        #1;
        check("stall_pc_hold", Pc_out, m_pc);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [5:0] r;
            r[5] = ($urandom_range(0, 7) == 0);
            r[4] = ($urandom_range(0, 11) == 0);
            r[3] = ($urandom_range(0, 3) == 0);
            r[2] = ($urandom_range(0, 3) == 0);
            r[1] = ($urandom_range(0, 4) == 0);
            r[0] = ($urandom_range(0, 3) == 0);
            run_cycle(r, $urandom, $urandom);
        end

        // Mid-cycle reset with a populated stack
        run_cycle(CALL, 32'h1000, 32'h0);
        run_cycle(CALL, 32'h2000, 32'h0);
        apply(JMP, 32'h3000, 32'h0);
        #2;
        Rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset_pc", Pc_out, 32'h0);
        check("midreset_count", 32'(Ras_count), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        run_cycle(NONE, 32'h0, 32'h0);
        run_cycle(RET, 32'h0, 32'h0);

        // 8-bit PC wraps modulo 2^8
        @(negedge Clk);
        rst8_n = 1'b1;
        repeat (63) @(posedge Clk);
        #1;
        check("w8_pc_fc", 32'(pc8_out), 32'h0000_00FC);
        check("w8_next_wrap", 32'(pc8_next), 32'h0);
        @(posedge Clk);
        #1;
        check("w8_pc_wrap", 32'(pc8_out), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
